output_sram_writer: RTL
=======================

Name: output_sram_writer

Overview:
- Sits directly downstream of the NUM_BANKS vertex accumulation buffers.
- Each buffer pulses a one-cycle output request when its node's feature vector (FV) is complete. This block latches that request, grants banks one at a time in round-robin order, and captures the granted bank's 2-FV-per-beat stream.
- Each beat is written into the output feature SRAM at a node-indexed address.
- Reports node completion and protocol errors.

Parameters:
- NUM_BANKS, 4, number of upstream vertex buffers.
- FV_SIZE, 16, bits per FV element.
- MAX_FV_NUM, 16, maximum FV elements per node (even).
- MAX_NODE_ID, 1024, number of node ids.
- BEATS_PER_NODE, MAX_FV_NUM/2, SRAM rows reserved per node.
- ADDR_W, clog2(MAX_NODE_ID*BEATS_PER_NODE), SRAM address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bank_req  in  NUM_BANKS  one-cycle output request per bank
- bank_grant_valid  in  NUM_BANKS  per-bank beat valid
- bank_sos  in  NUM_BANKS  per-bank start-of-stream
- bank_eos  in  NUM_BANKS  per-bank end-of-stream
- bank_data  in  NUM_BANKS x 2 x FV_SIZE  per-bank beat data; element [0] is the lower FV index
- bank_node_id  in  NUM_BANKS x clog2(MAX_NODE_ID)  per-bank node id
- req_grant  out  NUM_BANKS  one-hot grant, one-cycle pulse, registered
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM write address
- sram_wdata  out  2*FV_SIZE  {data[1],data[0]}
- node_done  out  1  one-cycle pulse when a node stream completes
- node_done_id  out  clog2(MAX_NODE_ID)  node id of completed stream
- node_done_beats  out  clog2(BEATS_PER_NODE)+1  beats written for that node
- proto_err  out  1  sticky protocol-error flag
- busy  out  1  high whenever state != IDLE or any pending bit is set

Behaviour:
- Reset (asynchronous): state=IDLE, pending=0, rr_ptr=0. All outputs are 0, including proto_err.
- pending[i] is set on bank_req[i] and cleared in the cycle grant[i] is issued. If set and clear coincide, set wins, so a new job is held pending.
- IDLE:
  - If any pending bit (registered value) is set, select the first set bit searching from rr_ptr upward with wrap.
  - Register sel, drive req_grant[sel]=1 next cycle, go to GRANT, set rr_ptr=sel+1 mod NUM_BANKS.
  - A bank_req arriving in the same cycle is not visible until the next cycle.
- GRANT (req_grant[sel]=1 for exactly this cycle):
  - The bank responds combinationally with grant_valid[sel]=1 and sos[sel]=1.
  - Write beat 0: sram_we=1, sram_addr = node_id*BEATS_PER_NODE + 0. Latch node_id, beat_cnt=1.
  - If eos is also set: issue node_done next cycle, go to IDLE. Otherwise go to STREAM.
  - If grant_valid[sel]=0 or sos[sel]=0: set proto_err, no write, go to IDLE.
- STREAM:
  - Each cycle with grant_valid[sel]=1: write at latched_node*BEATS_PER_NODE + beat_cnt, then beat_cnt++.
  - On eos[sel]: write that beat, pulse node_done next cycle with id and beats, go to IDLE.
  - grant_valid[sel]=0 in STREAM is a stall: no write, no error.
  - sos[sel]=1 in STREAM: set proto_err and treat the beat as ordinary data.
- Overflow: when beat_cnt == BEATS_PER_NODE, any further beat sets proto_err and is dropped (sram_we=0). The stream is still tracked until eos.
- Signals from non-selected banks are ignored at all times.
- sram_we, sram_addr and sram_wdata are combinational from registered state and the selected bank's inputs, giving zero-cycle write latency. The address multiply uses shift when BEATS_PER_NODE is a power of two (required).
- A node_done pulse occurs in the IDLE cycle following eos. Arbitration may select the next bank in that same cycle.
- Throughput: one IDLE cycle between streams. Back-to-back granting of the same bank is allowed only if it re-requested.

Decomposition:
- Shared package:
  - Bank_Req2Req_Output_SRAM-compatible per-bank beat struct.
  - FV_size, MAX_FV_num and Max_Node_id constants.
  - State enum {IDLE, GRANT, STREAM}.
- Sub-module rr_arbiter (NUM_BANKS): pending vector plus pointer in, one-hot select and valid out. Purely combinational, so it is reusable by other bank arbiters.

Test Plan:
- Single stream: bank 1 req, node_id=5, 3 beats (sos, mid, eos) with data 0x0001_0002, 0x0003_0004, 0x0005_0006 -> grant[1] one cycle later; writes at addr 40, 41, 42; node_done id=5, beats=3.
- Simultaneous req on banks 0, 2, 3 with rr_ptr=0 -> grant order 0, 2, 3; each stream completes before the next grant; rr_ptr ends at 0.
- Single-beat node: sos and eos in GRANT, node_id=0 -> one write at addr 0, node_done beats=1, back in IDLE after 1 cycle.
- Bank 2 re-requests while its own stream is in STREAM -> pending[2] remains set; bank 2 is granted again after the other pending banks.
- Missing sos in GRANT -> proto_err=1 (sticky), no write. Then 9 beats from node 3 (BEATS_PER_NODE=8) -> 8 writes at addr 24..31, beat 9 dropped.
- Reset asserted mid-STREAM -> all outputs 0 immediately; pending cleared; a new request after reset is serviced from rr_ptr=0.

Source files
------------

// File: rtl/output_sram_writer_pkg.sv
// -----------------------------------------------------------------------------
// output_sram_writer_pkg
// Shared constants and types for the output SRAM writer and its arbiter.
//   FV_SIZE        : bits per feature-vector element
//   MAX_FV_NUM     : maximum FV elements per node (even, two per beat)
//   MAX_NODE_ID    : number of node ids
//   NUM_BANKS      : number of upstream vertex accumulation buffers
//   BEATS_PER_NODE : SRAM rows reserved per node (must be a power of two)
//   bank_beat_t    : one bank's beat as seen by the writer
//   state_t        : writer FSM states
// -----------------------------------------------------------------------------
package output_sram_writer_pkg;

   localparam int FV_SIZE        = 16;
   localparam int MAX_FV_NUM     = 16;
   localparam int MAX_NODE_ID    = 1024;
   localparam int NUM_BANKS      = 4;
   localparam int BEATS_PER_NODE = MAX_FV_NUM / 2;

   localparam int NODE_W     = $clog2(MAX_NODE_ID);
   localparam int ADDR_W     = $clog2(MAX_NODE_ID * BEATS_PER_NODE);
   localparam int BEAT_SHIFT = $clog2(BEATS_PER_NODE);
   localparam int BEAT_W     = $clog2(BEATS_PER_NODE) + 1;
   localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   // Per-bank beat; data[0] holds the lower FV index.
   typedef struct packed {
      logic                        valid;
      logic                        sos;
      logic                        eos;
      logic [NODE_W-1:0]           node_id;
      logic [1:0][FV_SIZE-1:0]     data;
   } bank_beat_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Round-robin successor of a bank index, wrapping at NUM_BANKS.
   function automatic logic [BANK_W-1:0] rr_next(input logic [BANK_W-1:0] idx);
      return (idx == BANK_W'(NUM_BANKS - 1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/output_sram_writer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: returns the first set bit of
// 'pending' searching upward from 'ptr' with wrap-around.
//   pending : request vector
//   ptr     : index where the search starts
//   grant   : one-hot selected bank (zero when nothing pending)
//   valid   : at least one bit pending
//   idx     : binary index of the selected bank
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_BANKS = 4,
   localparam int IDX_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic [NUM_BANKS-1:0] pending,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_BANKS-1:0] grant,
   output logic                 valid,
   output logic [IDX_W-1:0]     idx
);

   int cand;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         cand = (int'(ptr) + k) % NUM_BANKS;
         if (!valid && pending[cand]) begin
            valid       = 1'b1;
            idx         = IDX_W'(cand);
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_sram_writer.sv
// -----------------------------------------------------------------------------
// output_sram_writer
// Collects completed node feature vectors from NUM_BANKS vertex buffers and
// writes them into the output feature SRAM, one bank stream at a time.
//   clk, reset        : clock, asynchronous active-high reset
//   bank_req          : one-cycle "node ready" pulse per bank
//   bank_grant_valid  : per-bank beat valid
//   bank_sos/eos      : per-bank start/end of stream
//   bank_data         : per-bank beat, two FV elements
//   bank_node_id      : per-bank node id (sampled on the first beat)
//   req_grant         : registered one-hot grant pulse
//   sram_we/addr/wdata: zero-latency SRAM write port
//   node_done*        : completion pulse with node id and beats written
//   proto_err         : sticky protocol error
//   busy              : FSM active or requests pending
// -----------------------------------------------------------------------------
module output_sram_writer
   import output_sram_writer_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_BANKS-1:0]                  bank_req,
   input  logic [NUM_BANKS-1:0]                  bank_grant_valid,
   input  logic [NUM_BANKS-1:0]                  bank_sos,
   input  logic [NUM_BANKS-1:0]                  bank_eos,
   input  logic [NUM_BANKS-1:0][1:0][FV_SIZE-1:0] bank_data,
   input  logic [NUM_BANKS-1:0][NODE_W-1:0]      bank_node_id,
   output logic [NUM_BANKS-1:0]                  req_grant,
   output logic                                  sram_we,
   output logic [ADDR_W-1:0]                     sram_addr,
   output logic [2*FV_SIZE-1:0]                  sram_wdata,
   output logic                                  node_done,
   output logic [NODE_W-1:0]                     node_done_id,
   output logic [BEAT_W-1:0]                     node_done_beats,
   output logic                                  proto_err,
   output logic                                  busy
);

   state_t                 state_reg;
   logic [NUM_BANKS-1:0]   pending_reg;
   logic [BANK_W-1:0]      rr_ptr_reg;
   logic [BANK_W-1:0]      sel_reg;
   logic [NODE_W-1:0]      node_reg;
   logic [BEAT_W-1:0]      beat_cnt_reg;

   logic [NUM_BANKS-1:0]   arb_grant;
   logic                   arb_valid;
   logic [BANK_W-1:0]      arb_idx;

   bank_beat_t             beat_vec [NUM_BANKS];
   bank_beat_t             cur;

   logic                   wr_en;
   logic [NODE_W-1:0]      wr_node;
   logic [BEAT_SHIFT-1:0]  wr_row;

   // Bundle each bank's loose inputs into one struct so the selected bank
   // can be picked with a single index.
   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign beat_vec[gi] = '{valid:   bank_grant_valid[gi],
                              sos:     bank_sos[gi],
                              eos:     bank_eos[gi],
                              node_id: bank_node_id[gi],
                              data:    bank_data[gi]};
   end

   // Only the selected bank is ever looked at; everything else is ignored.
   assign cur = beat_vec[sel_reg];

   rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb (
      .pending (pending_reg),
      .ptr     (rr_ptr_reg),
      .grant   (arb_grant),
      .valid   (arb_valid),
      .idx     (arb_idx)
   );

   // Write decision. In GRANT the node id comes straight from the bank
   // because it is only latched at the end of that cycle.
   always_comb begin
      wr_en   = 1'b0;
      wr_node = node_reg;
      wr_row  = beat_cnt_reg[BEAT_SHIFT-1:0];
      case (state_reg)
         GRANT: begin
            wr_en   = cur.valid & cur.sos;
            wr_node = cur.node_id;
            wr_row  = '0;
         end
         STREAM: begin
            // A full node drops any further beat.
            wr_en = cur.valid & (beat_cnt_reg != BEAT_W'(BEATS_PER_NODE));
         end
         default: ;
      endcase
   end

   // node_id*BEATS_PER_NODE + row as a concatenation (power-of-two rows).
   assign sram_we    = wr_en;
   assign sram_addr  = wr_en ? {wr_node, wr_row} : '0;
   assign sram_wdata = wr_en ? cur.data : '0;

   assign busy = (state_reg != IDLE) | (|pending_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         pending_reg     <= '0;
         rr_ptr_reg      <= '0;
         sel_reg         <= '0;
         node_reg        <= '0;
         beat_cnt_reg    <= '0;
         req_grant       <= '0;
         node_done       <= 1'b0;
         node_done_id    <= '0;
         node_done_beats <= '0;
         proto_err       <= 1'b0;
      end else begin
         // Clear on the grant cycle, but a fresh request in that cycle wins.
         pending_reg <= (pending_reg & ~req_grant) | bank_req;
         req_grant   <= '0;
         node_done   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (arb_valid) begin
                  sel_reg    <= arb_idx;
                  req_grant  <= arb_grant;
                  rr_ptr_reg <= rr_next(arb_idx);
                  state_reg  <= GRANT;
               end
            end

            GRANT: begin
               if (cur.valid && cur.sos) begin
                  node_reg     <= cur.node_id;
                  beat_cnt_reg <= BEAT_W'(1);
                  if (cur.eos) begin
                     node_done       <= 1'b1;
                     node_done_id    <= cur.node_id;
                     node_done_beats <= BEAT_W'(1);
                     state_reg       <= IDLE;
                  end else begin
                     state_reg <= STREAM;
                  end
               end else begin
                  // Bank did not answer the grant correctly; abandon it.
                  proto_err <= 1'b1;
                  state_reg <= IDLE;
               end
            end

            STREAM: begin
               if (cur.valid) begin
                  if (cur.sos) begin
                     proto_err <= 1'b1;
                  end
                  if (wr_en) begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  end else begin
                     proto_err <= 1'b1;
                  end
                  if (cur.eos) begin
                     node_done       <= 1'b1;
                     node_done_id    <= node_reg;
                     node_done_beats <= beat_cnt_reg + BEAT_W'(wr_en);
                     state_reg       <= IDLE;
                  end
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
